// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register.
// Contents: the mode code enumeration and a helper that classifies the shift-type modes,
// which are the modes that advance the word counter.
package universal_shift_register_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    ModeHold = 3'd0,
    ModeShl  = 3'd1,
    ModeShr  = 3'd2,
    ModeLoad = 3'd3,
    ModeRol  = 3'd4,
    ModeRor  = 3'd5,
    ModeAsr  = 3'd6,
    ModeRsvd = 3'd7
  } mode_e;

  function automatic logic is_shift_mode(mode_e m);
    return (m inside {ModeShl, ModeShr, ModeRol, ModeRor, ModeAsr});
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Bus interface for the universal shift register.
// master: drives en, mode, sin_lsb, sin_msb, d; observes q, sout_msb, sout_lsb, word_done.
// slave : the register itself (inputs and outputs reversed).
interface universal_shift_register_if #(
  parameter int unsigned WIDTH = 8
);
  import universal_shift_register_pkg::*;

  logic              en;
  logic [MODE_W-1:0] mode;
  logic              sin_lsb;
  logic              sin_msb;
  logic [WIDTH-1:0]  d;
  logic [WIDTH-1:0]  q;
  logic              sout_msb;
  logic              sout_lsb;
  logic              word_done;

  modport master (
    output en, mode, sin_lsb, sin_msb, d,
    input  q, sout_msb, sout_lsb, word_done
  );

  modport slave (
    input  en, mode, sin_lsb, sin_msb, d,
    output q, sout_msb, sout_lsb, word_done
  );

endinterface

// File: rtl/universal_shift_register_shift_counter.sv
// Word counter for the universal shift register.
// Counts shift-type operations; on the WIDTH-th one it wraps to zero and raises o_wrap for
// exactly the following cycle.
// Ports: i_clk, i_reset (sync, active-high), i_inc (count one shift), i_clr (restart the word),
//        o_wrap (registered one-cycle word-complete pulse).
module universal_shift_register_shift_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_wrap
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (i_inc) begin
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_wrap <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign o_wrap = r_wrap;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: WIDTH-bit register with hold, logical shift left/right,
// rotate left/right, arithmetic shift right and parallel load, selected per cycle by mode.
// Ports: i_clk, i_reset (sync, active-high), io_bus (slave modport: en, mode, sin_lsb, sin_msb,
//        d in; q, sout_msb, sout_lsb, word_done out).
// word_done pulses for one cycle after every WIDTH-th enabled shift-type operation.
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  universal_shift_register_if.slave         io_bus
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  mode_e            w_mode;
  logic             w_inc;
  logic             w_clr;
  logic             w_wrap;

  assign w_mode = mode_e'(io_bus.mode);

  // Serial inputs are only referenced inside their own shift arms, so an undriven tap
  // cannot leak into q in any other mode.
  always_comb begin
    w_q_next = r_q;
    if (io_bus.en) begin
      case (w_mode)
        ModeShl:  w_q_next = {r_q[WIDTH-2:0], io_bus.sin_lsb};
        ModeShr:  w_q_next = {io_bus.sin_msb, r_q[WIDTH-1:1]};
        ModeLoad: w_q_next = io_bus.d;
        ModeRol:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        ModeRor:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
        ModeAsr:  w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        default:  w_q_next = r_q;
      endcase
    end
  end

  assign w_inc = io_bus.en && is_shift_mode(w_mode);
  assign w_clr = io_bus.en && (w_mode == ModeLoad);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= w_q_next;
    end
  end

  universal_shift_register_shift_counter #(
    .WIDTH (WIDTH)
  ) u_shift_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_inc),
    .i_clr   (w_clr),
    .o_wrap  (w_wrap)
  );

  assign io_bus.q         = r_q;
  assign io_bus.sout_msb  = r_q[WIDTH-1];
  assign io_bus.sout_lsb  = r_q[0];
  assign io_bus.word_done = w_wrap;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8). A second instance with
// RESET_VALUE=3C receives identical stimulus and is checked only for its reset value.
module tb_universal_shift_register;

  localparam int unsigned W = 8;
  localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, LOAD = 3'd3;
  localparam logic [2:0] ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, RSVD = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  universal_shift_register_if #(.WIDTH(W)) bus1 ();
  universal_shift_register_if #(.WIDTH(W)) bus2 ();

  universal_shift_register #(
    .WIDTH       (W),
    .RESET_VALUE (8'h00)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus1.slave)
  );

  universal_shift_register #(
    .WIDTH       (W),
    .RESET_VALUE (8'h3C)
  ) dut_rv (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus2.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: register value, shifts since word start, word_done pulse.
  logic [7:0] m_q = 8'h00;
  int         m_cnt = 0;
  logic       m_done = 1'b0;

  task automatic model_step(input logic rst, input logic en, input logic [2:0] mode,
                            input logic sl, input logic sm, input logic [7:0] d);
    logic shift;
    shift = 1'b0;
    if (rst) begin
      m_q = 8'h00; m_cnt = 0; m_done = 1'b0;
    end else if (!en) begin
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      case (mode)
        SHL:  begin m_q = (m_q << 1) | {7'd0, sl}; shift = 1'b1; end
        SHR:  begin m_q = (m_q >> 1) | (sm ? 8'h80 : 8'h00); shift = 1'b1; end
        ROL:  begin m_q = (m_q << 1) | (m_q >> 7); shift = 1'b1; end
        ROR:  begin m_q = (m_q >> 1) | (m_q << 7); shift = 1'b1; end
        ASR:  begin m_q = 8'($signed(m_q) >>> 1); shift = 1'b1; end
        LOAD: begin m_q = d; m_cnt = 0; end
        default: ;
      endcase
      if (shift) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == 8) begin
          m_cnt = 0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  // Drive one clock of stimulus to both instances, advance the model, sample #1 after edge.
  task automatic cyc(input logic rst, input logic en, input logic [2:0] mode,
                     input logic sl, input logic sm, input logic [7:0] d);
    reset = rst;
    bus1.en = en; bus1.mode = mode; bus1.sin_lsb = sl; bus1.sin_msb = sm; bus1.d = d;
    bus2.en = en; bus2.mode = mode; bus2.sin_lsb = sl; bus2.sin_msb = sm; bus2.d = d;
    model_step(rst, en, mode, sl, sm, d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, LOAD, 1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, LOAD, 1'b1, 1'b1, 8'hFF);
    n_total++;
    if (bus1.q !== 8'h00) $display("FAIL reset_q got %h want 00", bus1.q);
    else n_pass++;
    n_total++;
    if ({bus1.word_done, bus1.sout_msb, bus1.sout_lsb} !== 3'b000)
      $display("FAIL reset_flags got wd/msb/lsb=%b want 000",
               {bus1.word_done, bus1.sout_msb, bus1.sout_lsb});
    else n_pass++;
    n_total++;
    if (bus2.q !== 8'h3C) $display("FAIL reset_value_q got %h want 3c", bus2.q);
    else n_pass++;
  endtask

  task automatic test_shl_serial();
    logic [7:0] bits;
    bits = 8'b1100_1011;  // bits[7] is shifted in first
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, SHL, bits[7-i], 1'b0, 8'h00);
      n_total++;
      if (bus1.word_done !== (i == 7))
        $display("FAIL shl_wd step %0d got %b want %b", i, bus1.word_done, (i == 7));
      else n_pass++;
    end
    n_total++;
    if (bus1.q !== 8'hCB) $display("FAIL shl_q got %h want cb", bus1.q);
    else n_pass++;
    cyc(1'b0, 1'b1, HOLD, 1'b1, 1'b1, 8'h00);
    n_total++;
    if (bus1.word_done !== 1'b0 || bus1.q !== 8'hCB)
      $display("FAIL shl_after got wd=%b q=%h want wd=0 q=cb", bus1.word_done, bus1.q);
    else n_pass++;
  endtask

  task automatic test_load_shr();
    cyc(1'b0, 1'b1, LOAD, 1'b0, 1'b0, 8'hA5);
    n_total++;
    if (bus1.q !== 8'hA5 || bus1.sout_lsb !== 1'b1 || bus1.sout_msb !== 1'b1)
      $display("FAIL load_a5 got q=%h lsb=%b msb=%b want a5 1 1",
               bus1.q, bus1.sout_lsb, bus1.sout_msb);
    else n_pass++;
    cyc(1'b0, 1'b1, SHR, 1'b1, 1'b0, 8'h00);
    n_total++;
    if (bus1.q !== 8'h52 || bus1.sout_lsb !== 1'b0)
      $display("FAIL shr_52 got q=%h lsb=%b want 52 0", bus1.q, bus1.sout_lsb);
    else n_pass++;
    // Counter now at 1: the 7th further shift completes the word.
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, SHR, 1'b0, 1'($urandom_range(1)), 8'h00);
      n_total++;
      if (bus1.word_done !== (i == 6) || bus1.q !== m_q)
        $display("FAIL shr_word step %0d got wd=%b q=%h want wd=%b q=%h",
                 i, bus1.word_done, bus1.q, (i == 6), m_q);
      else n_pass++;
    end
  endtask

  task automatic test_rotate_asr();
    logic [2:0]  modes [5] = '{ROL, ROR, ASR, ASR, RSVD};
    logic [7:0]  start [5] = '{8'h81, 8'h81, 8'h80, 8'h40, 8'h5A};
    logic [7:0]  want  [5] = '{8'h03, 8'hC0, 8'hC0, 8'h20, 8'h5A};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, LOAD, 1'b0, 1'b0, start[i]);
      cyc(1'b0, 1'b1, modes[i], 1'($urandom_range(1)), 1'($urandom_range(1)), 8'h00);
      n_total++;
      if (bus1.q !== want[i])
        $display("FAIL op_mode%0d on %h got %h want %h", modes[i], start[i], bus1.q, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    logic [7:0] v;
    v = 8'($urandom);
    cyc(1'b0, 1'b1, LOAD, 1'b0, 1'b0, v);
    cyc(1'b0, 1'b1, SHL, 1'b1, 1'b0, 8'h00);  // counter = 1
    v = m_q;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, SHL, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom));
      n_total++;
      if (bus1.q !== v || bus1.word_done !== 1'b0)
        $display("FAIL en0_hold cycle %0d got q=%h wd=%b want q=%h wd=0",
                 i, bus1.q, bus1.word_done, v);
      else n_pass++;
    end
    // Counter held at 1 through en=0, so the 7th enabled shift completes the word.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, SHL, 1'($urandom_range(1)), 1'b0, 8'h00);
      n_total++;
      if (bus1.word_done !== (i == 6) || bus1.q !== m_q)
        $display("FAIL en_shl step %0d got wd=%b q=%h want wd=%b q=%h",
                 i, bus1.word_done, bus1.q, (i == 6), m_q);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_word();
    logic seen;
    cyc(1'b0, 1'b1, LOAD, 1'b0, 1'b0, 8'h96);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, ROL, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, SHL, 1'b1, 1'b1, 8'h00);
    n_total++;
    if (bus2.q !== 8'h3C || bus1.q !== 8'h00)
      $display("FAIL midreset_q got q=%h q_rv=%h want 00 3c", bus1.q, bus2.q);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, SHR, 1'b0, 1'($urandom_range(1)), 8'h00);
      seen = seen | bus1.word_done;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL midreset_7 got wd seen=%b want 0", seen);
    else n_pass++;
    cyc(1'b0, 1'b1, SHR, 1'b0, 1'b1, 8'h00);
    n_total++;
    if (bus1.word_done !== 1'b1) $display("FAIL midreset_8 got wd=%b want 1", bus1.word_done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] sm [5] = '{SHL, SHR, ROL, ROR, ASR};
    cyc(1'b0, 1'b1, LOAD, 1'b0, 1'b0, 8'($urandom));
    for (int i = 1; i <= 24; i++) begin
      cyc(1'b0, 1'b1, sm[$urandom_range(4)], 1'($urandom_range(1)), 1'($urandom_range(1)),
          8'h00);
      n_total++;
      if (bus1.word_done !== (i % 8 == 0) || bus1.q !== m_q)
        $display("FAIL b2b shift %0d got wd=%b q=%h want wd=%b q=%h",
                 i, bus1.word_done, bus1.q, (i % 8 == 0), m_q);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(39) == 0), ($urandom_range(4) != 0), 3'($urandom),
          1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom));
      n_total++;
      if ({bus1.q, bus1.sout_msb, bus1.sout_lsb, bus1.word_done} !==
          {m_q, m_q[7], m_q[0], m_done})
        $display("FAIL random cycle %0d got q=%h msb=%b lsb=%b wd=%b want q=%h wd=%b",
                 i, bus1.q, bus1.sout_msb, bus1.sout_lsb, bus1.word_done, m_q, m_done);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_shl_serial();
    test_load_shr();
    test_rotate_asr();
    test_enable();
    test_reset_mid_word();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
